// File: rtl/akuma_pkg.sv
// Shared definitions for the Akuma per-frame sprite controllers.
//   death_state_t : KO/death animation sequencer states
//   screen/sprite geometry and the derived rightmost legal sprite X
//   kb_step_x     : one clamped knockback step of the sprite X
package akuma_pkg;

  localparam int unsigned SCREEN_W      = 640;
  localparam int unsigned AKUMA_DEATH_W = 236;
  localparam int unsigned AKUMA_DEATH_H = 92;
  localparam int unsigned X_MAX         = SCREEN_W - AKUMA_DEATH_W;

  localparam int unsigned X_W    = 10;
  localparam int unsigned FCNT_W = 6;

  typedef enum logic [2:0] {
    ST_ALIVE,
    ST_KNOCKBACK,
    ST_FALL,
    ST_BLINK,
    ST_DONE
  } death_state_t;

  // One knockback step; arithmetic is one bit wider so +X cannot wrap.
  function automatic logic [X_W-1:0] kb_step_x(
    input logic [X_W-1:0] x,
    input logic           right,
    input int unsigned    step,
    input int unsigned    xmax
  );
    logic [X_W:0] x_ext;
    logic [X_W:0] step_ext;
    logic [X_W:0] sum;
    x_ext    = {1'b0, x};
    step_ext = (X_W+1)'(step);
    sum      = x_ext + step_ext;
    if (right) begin
      if (sum > (X_W+1)'(xmax)) kb_step_x = X_W'(xmax);
      else                      kb_step_x = sum[X_W-1:0];
    end else begin
      if (x_ext < step_ext) kb_step_x = '0;
      else                  kb_step_x = X_W'(x_ext - step_ext);
    end
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Converts the asynchronous vsync-rate frame_clk into a one-Clk tick pulse.
//   Clk       : system clock
//   Reset     : synchronous, active-high; clears all flops (no tick after reset)
//   frame_clk : frame strobe, level-sampled
//   tick      : registered 1-cycle pulse per frame_clk rising edge
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchroniser, edge flop, registered rising-edge pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      prev  <= sync2;
      tick  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/akuma_death_ctrl.sv
// Akuma KO/death animation sequencer, stepped once per video frame.
//   Clk, Reset     : clock, synchronous active-high reset
//   frame_clk      : vsync-rate strobe (synchronised internally)
//   live_x         : gameplay X, tracked while alive
//   ko             : health-zero level; starts the animation from ALIVE
//   knock_right    : knockback direction (1 = +X), latched on KO
//   restart        : pulse, returns to ALIVE from any state
//   AkumaX         : X for the sprite renderers
//   death_active   : select the death sprite layer
//   sprite_visible : Akuma layer gate (blinks during BLINK)
//   ko_done        : animation complete, held until restart
module akuma_death_ctrl
  import akuma_pkg::*;
#(
  parameter int unsigned KB_FRAMES    = 16,
  parameter int unsigned KB_STEP      = 4,
  parameter int unsigned FALL_FRAMES  = 8,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned BLINK_HALF   = 4,
  parameter int unsigned X_MAX        = akuma_pkg::X_MAX
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_clk,
  input  logic [X_W-1:0] live_x,
  input  logic           ko,
  input  logic           knock_right,
  input  logic           restart,
  output logic [X_W-1:0] AkumaX,
  output logic           death_active,
  output logic           sprite_visible,
  output logic           ko_done
);

  localparam int unsigned BLINK_BIT = $clog2(BLINK_HALF);

  death_state_t      state;
  death_state_t      state_n;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_n;
  logic [X_W-1:0]    x_n;
  logic              dir;
  logic              dir_n;
  logic              death_active_n;
  logic              sprite_visible_n;
  logic              ko_done_n;
  logic              tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Sequencer state, frame counter, X and all outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= ST_ALIVE;
      fcnt           <= '0;
      dir            <= 1'b0;
      AkumaX         <= '0;
      death_active   <= 1'b0;
      sprite_visible <= 1'b1;
      ko_done        <= 1'b0;
    end else begin
      state          <= state_n;
      fcnt           <= fcnt_n;
      dir            <= dir_n;
      AkumaX         <= x_n;
      death_active   <= death_active_n;
      sprite_visible <= sprite_visible_n;
      ko_done        <= ko_done_n;
    end
  end

  // Next state, counter, X and outputs; restart overrides everything.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    dir_n   = dir;
    x_n     = AkumaX;

    case (state)
      ST_ALIVE: begin
        x_n = live_x;
        if (ko) begin
          state_n = ST_KNOCKBACK;
          fcnt_n  = '0;
          dir_n   = knock_right;
        end
      end
      ST_KNOCKBACK: begin
        if (tick) begin
          x_n = kb_step_x(AkumaX, dir, KB_STEP, X_MAX);
          if (fcnt == FCNT_W'(KB_FRAMES - 1)) begin
            state_n = ST_FALL;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FCNT_W'(1);
          end
        end
      end
      ST_FALL: begin
        if (tick) begin
          if (fcnt == FCNT_W'(FALL_FRAMES - 1)) begin
            state_n = ST_BLINK;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FCNT_W'(1);
          end
        end
      end
      ST_BLINK: begin
        if (tick) begin
          if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
            state_n = ST_DONE;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FCNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_DONE;
      end
      default: begin
        state_n = ST_ALIVE;
        fcnt_n  = '0;
      end
    endcase

    // X is held on the restart edge; tracking resumes from the next cycle.
    if (restart) begin
      state_n = ST_ALIVE;
      fcnt_n  = '0;
      x_n     = AkumaX;
    end

    death_active_n   = (state_n != ST_ALIVE);
    ko_done_n        = (state_n == ST_DONE);
    sprite_visible_n = (state_n == ST_BLINK) ? ~fcnt_n[BLINK_BIT] : 1'b1;
  end

endmodule
